// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory-side arbiter: CPU/RAM types and arbiter FSM types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

package aww_types_pkg;
  typedef enum logic {IDLE, SERVE} arb_state_t;
  typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} req_kind_t;
endpackage

// File: rtl/rr_picker.sv
// Round-robin first-set-bit search: first req bit at or after ptr+1, mod N.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);
  assign any = |req;

  // Scan from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    logic [W-1:0] j;
    j   = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// Memory-side arbiter: grants one icache/dcache request at a time onto the RAM,
// data before instruction, round-robin within a class.
module memory_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int NCPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCPUS-1:0]       iREN,
  input  logic [NCPUS-1:0][31:0] iaddr,
  input  logic [NCPUS-1:0]       dREN,
  input  logic [NCPUS-1:0]       dWEN,
  input  logic [NCPUS-1:0][31:0] daddr,
  input  logic [NCPUS-1:0][31:0] dstore,
  output logic [NCPUS-1:0]       iwait,
  output logic [NCPUS-1:0]       dwait,
  output logic [NCPUS-1:0][31:0] iload,
  output logic [NCPUS-1:0][31:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  ramstate_t              ramstate
);
  localparam int CW = (NCPUS > 1) ? $clog2(NCPUS) : 1;
  typedef logic [CW-1:0] cpuid_t;

  arb_state_t state, state_n;
  req_kind_t  gkind, gkind_n;
  cpuid_t     gcpu, gcpu_n, rr_ptr, rr_n;
  cpuid_t     dpick, ipick;
  logic       dany, iany, live;
  logic [NCPUS-1:0] dreq;

  assign dreq  = dREN | dWEN;
  assign iload = {NCPUS{ramload}};
  assign dload = {NCPUS{ramload}};

  rr_picker #(.N(NCPUS), .W(CW)) u_dpick (.req(dreq), .ptr(rr_ptr), .any(dany), .idx(dpick));
  rr_picker #(.N(NCPUS), .W(CW)) u_ipick (.req(iREN), .ptr(rr_ptr), .any(iany), .idx(ipick));

  // State, latched grant and round-robin pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      gcpu   <= '0;
      gkind  <= IFETCH;
      rr_ptr <= cpuid_t'(NCPUS - 1);
    end else begin
      state  <= state_n;
      gcpu   <= gcpu_n;
      gkind  <= gkind_n;
      rr_ptr <= rr_n;
    end
  end

  // Grant in IDLE; in SERVE drive RAM from the granted CPU's live request.
  always_comb begin
    state_n  = state;
    gcpu_n   = gcpu;
    gkind_n  = gkind;
    rr_n     = rr_ptr;
    iwait    = '1;
    dwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    live     = 1'b0;
    case (state)
      IDLE: begin
        if (dany) begin
          gcpu_n  = dpick;
          gkind_n = dWEN[dpick] ? DWRITE : DREAD;
          state_n = SERVE;
        end else if (iany) begin
          gcpu_n  = ipick;
          gkind_n = IFETCH;
          state_n = SERVE;
        end
      end
      SERVE: begin
        case (gkind)
          IFETCH:  live = iREN[gcpu];
          DREAD:   live = dREN[gcpu];
          default: live = dWEN[gcpu];
        endcase
        if (!live) begin
          // Requester withdrew: abandon without completing or moving rr_ptr.
          state_n = IDLE;
        end else begin
          ramREN   = (gkind != DWRITE);
          ramWEN   = (gkind == DWRITE);
          ramaddr  = (gkind == IFETCH) ? iaddr[gcpu] : daddr[gcpu];
          ramstore = (gkind == DWRITE) ? dstore[gcpu] : '0;
          if (ramstate == ACCESS) begin
            if (gkind == IFETCH) iwait[gcpu] = 1'b0;
            else                 dwait[gcpu] = 1'b0;
            rr_n    = gcpu;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: cycle-by-cycle vector table plus corner sequences.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam logic [31:0] LOAD = 32'hDEADBEEF;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][31:0]  iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][31:0]  iload, dload;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  ramstate_t         ramstate;

  int nvec = 0;
  int nerr = 0;

  memory_arbiter #(.NCPUS(2)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  iren, dren, dwen;
    ramstate_t   rs;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [1:0]  iw, dw;
  } vec_t;

  vec_t tv[20];

  function automatic vec_t mk(logic [1:0] ir, logic [1:0] dr, logic [1:0] dw_, ramstate_t rs,
                              logic ren, logic wen, logic [31:0] a, logic [31:0] s,
                              logic [1:0] eiw, logic [1:0] edw);
    vec_t v;
    v.iren = ir; v.dren = dr; v.dwen = dw_; v.rs = rs;
    v.ren = ren; v.wen = wen; v.addr = a; v.store = s; v.iw = eiw; v.dw = edw;
    return v;
  endfunction

  task automatic chk(string nm, logic ren, logic wen, logic [31:0] a, logic [31:0] s,
                     logic [1:0] eiw, logic [1:0] edw);
    nvec++;
    if (ramREN !== ren || ramWEN !== wen || ramaddr !== a || ramstore !== s ||
        iwait !== eiw || dwait !== edw || iload !== {2{LOAD}} || dload !== {2{LOAD}}) begin
      nerr++;
      $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b iload0=%h dload1=%h; want ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b load=%h",
               nm, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload[0], dload[1],
               ren, wen, a, s, eiw, edw, LOAD);
    end
  endtask

  task automatic cyc(string nm, logic [1:0] ir, logic [1:0] dr, logic [1:0] dw_, ramstate_t rs,
                     logic ren, logic wen, logic [31:0] a, logic [31:0] s,
                     logic [1:0] eiw, logic [1:0] edw);
    @(negedge CLK);
    iREN = ir; dREN = dr; dWEN = dw_; ramstate = rs;
    #1;
    chk(nm, ren, wen, a, s, eiw, edw);
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr[0] = 32'h40;   iaddr[1] = 32'h140;
    daddr[0] = 32'h200;  daddr[1] = 32'h80;
    dstore[0] = 32'h5555; dstore[1] = 32'h1234;
    ramload = LOAD;
    ramstate = FREE;

    // Cycle-accurate table; state/rr_ptr evolve from reset through each entry.
    tv[0]  = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[1]  = mk(2'b01, 2'b00, 2'b00, BUSY,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[2]  = mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, 32'h40,  32'h0,    2'b11, 2'b11);
    tv[3]  = mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, 32'h40,  32'h0,    2'b11, 2'b11);
    tv[4]  = mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40,  32'h0,    2'b10, 2'b11);
    tv[5]  = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[6]  = mk(2'b01, 2'b00, 2'b10, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[7]  = mk(2'b01, 2'b00, 2'b10, ACCESS, 0, 1, 32'h80,  32'h1234, 2'b11, 2'b01);
    tv[8]  = mk(2'b01, 2'b00, 2'b00, ACCESS, 0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[9]  = mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40,  32'h0,    2'b10, 2'b11);
    tv[10] = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[11] = mk(2'b00, 2'b10, 2'b00, ERROR,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[12] = mk(2'b00, 2'b10, 2'b00, ERROR,  1, 0, 32'h80,  32'h0,    2'b11, 2'b11);
    tv[13] = mk(2'b00, 2'b10, 2'b00, ERROR,  1, 0, 32'h80,  32'h0,    2'b11, 2'b11);
    tv[14] = mk(2'b00, 2'b10, 2'b00, ERROR,  1, 0, 32'h80,  32'h0,    2'b11, 2'b11);
    tv[15] = mk(2'b00, 2'b10, 2'b00, ACCESS, 1, 0, 32'h80,  32'h0,    2'b11, 2'b01);
    tv[16] = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[17] = mk(2'b00, 2'b01, 2'b01, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);
    tv[18] = mk(2'b00, 2'b01, 2'b01, ACCESS, 0, 1, 32'h200, 32'h5555, 2'b11, 2'b10);
    tv[19] = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11);

    #2;
    chk("reset", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 20; i++)
      cyc($sformatf("tv%0d", i), tv[i].iren, tv[i].dren, tv[i].dwen, tv[i].rs,
          tv[i].ren, tv[i].wen, tv[i].addr, tv[i].store, tv[i].iw, tv[i].dw);

    // Round robin: rr_ptr=0 here, so CPU1 first, then alternating, one IDLE between.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        cyc($sformatf("rr%0d_idle", k), 2'b11, 2'b00, 2'b00, ACCESS, 0, 0, 32'h0, 32'h0, 2'b11, 2'b11);
      else if (((k >> 1) & 1) == 0)
        cyc($sformatf("rr%0d_cpu1", k), 2'b11, 2'b00, 2'b00, ACCESS, 1, 0, 32'h140, 32'h0, 2'b01, 2'b11);
      else
        cyc($sformatf("rr%0d_cpu0", k), 2'b11, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40, 32'h0, 2'b10, 2'b11);
    end

    // Abort: CPU1 dREN drops mid-SERVE; rr_ptr must stay 0 so the next tie goes to CPU1.
    cyc("ab_grant", 2'b00, 2'b10, 2'b00, FREE, 0, 0, 32'h0,  32'h0, 2'b11, 2'b11);
    cyc("ab_busy",  2'b00, 2'b10, 2'b00, BUSY, 1, 0, 32'h80, 32'h0, 2'b11, 2'b11);
    cyc("ab_drop",  2'b00, 2'b00, 2'b00, BUSY, 0, 0, 32'h0,  32'h0, 2'b11, 2'b11);
    cyc("ab_idle",  2'b11, 2'b00, 2'b00, FREE, 0, 0, 32'h0,  32'h0, 2'b11, 2'b11);
    cyc("ab_rr",    2'b11, 2'b00, 2'b00, ACCESS, 1, 0, 32'h140, 32'h0, 2'b01, 2'b11);
    cyc("ab_done",  2'b00, 2'b00, 2'b00, FREE, 0, 0, 32'h0,  32'h0, 2'b11, 2'b11);

    // Reset mid-SERVE: outputs drop in the same cycle; afterwards CPU0 wins the tie.
    cyc("rst_grant", 2'b01, 2'b00, 2'b00, FREE, 0, 0, 32'h0,  32'h0, 2'b11, 2'b11);
    cyc("rst_serve", 2'b01, 2'b00, 2'b00, BUSY, 1, 0, 32'h40, 32'h0, 2'b11, 2'b11);
    #1 nRST = 1'b0;
    #1 chk("rst_async", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11);
    @(negedge CLK);
    nRST = 1'b1;
    iREN = 2'b11; ramstate = FREE;
    #1 chk("rst_idle", 0, 0, 32'h0, 32'h0, 2'b11, 2'b11);
    cyc("rst_tie",   2'b11, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40, 32'h0, 2'b10, 2'b11);
    cyc("rst_end",   2'b00, 2'b00, 2'b00, FREE, 0, 0, 32'h0,  32'h0, 2'b11, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
